// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Issue-stage scoreboard. Tracks in-flight writes to general registers,
//   FP registers and EFLAGS with one countdown timer per resource, and
//   asserts stall while the candidate micro-instruction reads a result that
//   is not yet forwardable (RAW) or would overwrite a pending destination
//   out of order (WAW).
//
//   Handshake: issue_valid presents a candidate; it issues in the cycle
//   where issue_fire = issue_valid & ~stall & ~flush. A stalled candidate
//   is expected to be held stable by the upstream stage.
//
// Ports
//   clk, rstn       clock, synchronous active-low reset
//   issue_valid     candidate micro-instruction present
//   rut             register usage record of the candidate
//   wb_latency      cycles from issue until the candidate's results forward
//   flush           discard all pending writes; suppresses issue_fire
//   stall           candidate must not issue this cycle
//   issue_fire      candidate issues this cycle
//   busy_gpr/fpr    per-register timer != 0 (also serves as state debug view)
//   busy_ef         EFLAGS timer != 0
//   stall_cycles    (only with SCOREBOARD_STATS_EN) count of issue_valid&stall
//
// Optional feature macro: SCOREBOARD_STATS_EN

package hazard_scoreboard_pkg;
  localparam int RUT_IDX_W = 5;

  typedef struct packed {
    logic [RUT_IDX_W-1:0] d;
    logic [RUT_IDX_W-1:0] s;
    logic [RUT_IDX_W-1:0] t;
    logic from_gd;
    logic from_fd;
    logic to_gd;
    logic to_fd;
    logic from_gs;
    logic from_fs;
    logic from_gt;
    logic from_ft;
    logic from_ef;
    logic to_ef;
  } rut_t;
endpackage

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_N = 16,
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  input  rut_t             rut,
  input  logic [LAT_W-1:0] wb_latency,
  input  logic             flush,
  output logic             stall,
  output logic             issue_fire,
  output logic [REG_N-1:0] busy_gpr,
  output logic [REG_N-1:0] busy_fpr,
  output logic             busy_ef
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int IDX_W = $clog2(REG_N);

  logic [LAT_W-1:0] gpr_q [REG_N];
  logic [LAT_W-1:0] gpr_d [REG_N];
  logic [LAT_W-1:0] fpr_q [REG_N];
  logic [LAT_W-1:0] fpr_d [REG_N];
  logic [LAT_W-1:0] ef_q;
  logic [LAT_W-1:0] ef_d;

  logic [IDX_W-1:0] d_idx;
  logic [IDX_W-1:0] s_idx;
  logic [IDX_W-1:0] t_idx;
  logic [LAT_W-1:0] lat_m1;
  logic             raw_hit;
  logic             waw_hit;
  logic             unused_idx_bits;

  assign d_idx = rut.d[IDX_W-1:0];
  assign s_idx = rut.s[IDX_W-1:0];
  assign t_idx = rut.t[IDX_W-1:0];
  // Upper index bits of the usage record are ignored by design.
  assign unused_idx_bits = ^{rut.d, rut.s, rut.t};

  // Value loaded on issue; latencies 0 and 1 both mean "forwardable next
  // cycle", so nothing needs tracking.
  assign lat_m1 = (wb_latency == '0) ? '0 : wb_latency - LAT_W'(1);

  always_comb begin
    for (int i = 0; i < REG_N; i++) begin
      busy_gpr[i] = (gpr_q[i] != '0);
      busy_fpr[i] = (fpr_q[i] != '0);
    end
  end
  assign busy_ef = (ef_q != '0);

  always_comb begin
    raw_hit = (rut.from_gs & busy_gpr[s_idx]) |
              (rut.from_gt & busy_gpr[t_idx]) |
              (rut.from_gd & busy_gpr[d_idx]) |
              (rut.from_fs & busy_fpr[s_idx]) |
              (rut.from_ft & busy_fpr[t_idx]) |
              (rut.from_fd & busy_fpr[d_idx]) |
              (rut.from_ef & busy_ef);
    // A new write may not retire before an older pending write to the same
    // resource, so its timer must not end up shorter than the existing one.
    waw_hit = (rut.to_gd & (gpr_q[d_idx] > lat_m1)) |
              (rut.to_fd & (fpr_q[d_idx] > lat_m1)) |
              (rut.to_ef & (ef_q > lat_m1));
  end

  assign stall      = issue_valid & (raw_hit | waw_hit);
  assign issue_fire = issue_valid & ~stall & ~flush;

  always_comb begin
    for (int i = 0; i < REG_N; i++) begin
      gpr_d[i] = (gpr_q[i] != '0) ? gpr_q[i] - LAT_W'(1) : '0;
      fpr_d[i] = (fpr_q[i] != '0) ? fpr_q[i] - LAT_W'(1) : '0;
      if (issue_fire && rut.to_gd && (d_idx == IDX_W'(i))) gpr_d[i] = lat_m1;
      if (issue_fire && rut.to_fd && (d_idx == IDX_W'(i))) fpr_d[i] = lat_m1;
      if (flush) begin
        gpr_d[i] = '0;
        fpr_d[i] = '0;
      end
    end
    ef_d = busy_ef ? ef_q - LAT_W'(1) : '0;
    if (issue_fire && rut.to_ef) ef_d = lat_m1;
    if (flush) ef_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < REG_N; i++) begin
        gpr_q[i] <= '0;
        fpr_q[i] <= '0;
      end
      ef_q <= '0;
    end else begin
      for (int i = 0; i < REG_N; i++) begin
        gpr_q[i] <= gpr_d[i];
        fpr_q[i] <= fpr_d[i];
      end
      ef_q <= ef_d;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Counts stalled candidates; flush does not clear it. Wraps naturally.
  assign stall_cnt_d = stall_cnt_q + {31'd0, stall};

  always_ff @(posedge clk) begin
    if (!rstn) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-stage scoreboard directly downstream of the register-usage decode. It consumes the per-micro-instruction `rut_t` usage record and tracks in-flight writes to general registers, FP registers and EFLAGS with per-register countdown timers. It asserts `stall` while the candidate instruction reads, or would out-of-order overwrite, a destination whose result is not yet forwardable. One instruction is considered per cycle; a flush clears all tracking.

## Interface
- `REG_N`, 16: registers per file (GPR and FPR); index = low `$clog2(REG_N)` bits of `rut.d/s/t`
- `LAT_W`, 3: width of latency field and of each countdown timer
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `issue_valid`  in  1  candidate micro-instruction present
- `rut`  in  `rut_t`  register usage record of candidate: d/s/t indices plus from_gd, from_fd, to_gd, to_fd, from_gs, from_fs, from_gt, from_ft, from_ef, to_ef
- `wb_latency`  in  LAT_W  cycles from issue until the candidate's results are forwardable
- `flush`  in  1  discard all pending writes (mispredict / redirect)
- `stall`  out  1  candidate must not issue this cycle
- `issue_fire`  out  1  `issue_valid & ~stall & ~flush`
- `busy_gpr`  out  REG_N  timer≠0 per GPR
- `busy_fpr`  out  REG_N  timer≠0 per FPR
- `busy_ef`  out  1  EFLAGS timer≠0

## Operation
- State: `REG_N` GPR timers, `REG_N` FPR timers, 1 EFLAGS timer, each LAT_W bits.
- Every cycle each nonzero timer decrements by 1; zero stays zero.
- RAW stall, when `issue_valid`:
  - `from_gs` and GPR[s] busy
  - `from_gt` and GPR[t] busy
  - `from_gd` and GPR[d] busy
  - `from_fs` / `from_ft` / `from_fd` and FPR[s/t/d] busy
  - `from_ef` and EFLAGS busy
- WAW stall: `to_gd` and GPR timer[d] > `wb_latency-1`; same for `to_fd`/FPR[d] and `to_ef`/EFLAGS.
- `stall` is the OR of all terms; it is 0 when `issue_valid`=0.
- On `issue_fire`: for each written resource (`to_gd`, `to_fd`, `to_ef`), load its timer with `wb_latency-1` (saturating at 0). `wb_latency` of 0 or 1 therefore records nothing. The load overrides the same-cycle decrement for that timer.
- Two write flags naming different resources are loaded independently; all others decrement.
- `flush`: all timers ← 0 next cycle; `issue_fire` forced 0 that cycle. `flush` has priority over issue.
- Reset (`rstn`=0 at posedge): all timers ← 0 → `stall`=0, `issue_fire`=`issue_valid`, all busy outputs 0. Reset mid-operation discards all pending state.

## Timing
- `stall`, `issue_fire`, busy outputs: combinational from current timers and inputs; zero-cycle latency.
- Timers update at posedge `clk`.
- A producer fired at cycle n with latency L lets a dependent consumer fire at cycle n+L at the earliest; at n+1..n+L-1 the consumer stalls.
- A timer expiring (1→0) in cycle n lets the consumer fire in cycle n+1.

## Configuration
- `SCOREBOARD_STATS_EN`:
  - Defined: adds output `stall_cycles` (32 bits), counting cycles with `issue_valid & stall`. Cleared by reset, not by flush, wraps at 2^32.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `issue_valid`=1 with a GPR read → `stall`=0, `issue_fire`=1, all busy outputs 0.
- Fire ADD d=3, L=3 at cycle 0; candidate with `from_gs`, s=3 → stalls cycles 1–2, fires cycle 3; `busy_gpr[3]`=1 in cycles 1–2.
- Fire write d=5, L=4; next cycle, write d=5, L=1 → WAW stall until timer[5]=0, then fires.
- Fire CMP (`to_ef`, L=2) at cycle 0; Jcc (`from_ef`) → stalls cycle 1, fires cycle 2.
- Pending GPR[2], L=5; assert `flush` at cycle 1 with `issue_valid` → `issue_fire`=0; cycle 2 all busy 0, a reader of GPR[2] fires.
- With `SCOREBOARD_STATS_EN`: the 2-cycle RAW stall above → `stall_cycles`=2; pulse `rstn` low → 0.
